// File: rtl/fsm_output.sv
// Presents a captured 64-bit result block as eleven 6-bit chunks, stepped by a
// filtered push-button, with the chunk index shown on an active-low 7-seg digit.
module fsm_output #(
  parameter int BLOCK_W = 64,
  parameter int CHUNK_W = 6,
  parameter int NCHUNK  = 11,
  parameter int DEB_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block,
  input  logic               btn,
  output logic [CHUNK_W-1:0] chunk,
  output logic [3:0]         idx,
  output logic               valid,
  output logic               done,
  output logic [6:0]         seven
);

  localparam logic [3:0] LAST = 4'(NCHUNK - 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  state_t             state, state_n;
  logic [BLOCK_W-1:0] captured, captured_n;
  logic [CHUNK_W-1:0] chunk_n;
  logic [3:0]         idx_n;
  logic               valid_n, done_n;
  logic [6:0]         seven_n;
  logic [DEB_LEN-1:0] sr;
  logic               lvl, lvl_d, step;

  // Shifting right leaves the top chunk zero-extended, which is exactly the
  // residual-bits rule for the last chunk.
  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [BLOCK_W-1:0] blk,
                                                  input logic [3:0] k);
    logic [BLOCK_W-1:0] sh;
    sh = blk >> (int'(k) * CHUNK_W);
    return sh[CHUNK_W-1:0];
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      4'd10:   seg = 7'b0001000;
      default: seg = BLANK;
    endcase
  endfunction

  // A press registers only after DEB_LEN consecutive high samples; the edge
  // detect on the filtered level turns a held button into a single step.
  assign lvl  = &sr;
  assign step = lvl & ~lvl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      captured <= '0;
      chunk    <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      seven    <= BLANK;
      sr       <= '0;
      lvl_d    <= 1'b0;
    end else begin
      state    <= state_n;
      captured <= captured_n;
      chunk    <= chunk_n;
      idx      <= idx_n;
      valid    <= valid_n;
      done     <= done_n;
      seven    <= seven_n;
      sr       <= {sr[DEB_LEN-2:0], btn};
      lvl_d    <= lvl;
    end
  end

  always_comb begin
    state_n    = state;
    captured_n = captured;
    chunk_n    = chunk;
    idx_n      = idx;
    valid_n    = valid;
    done_n     = done;
    if (load) begin
      state_n    = SHOW;
      captured_n = block;
      idx_n      = '0;
      chunk_n    = chunk_of(block, 4'd0);
      valid_n    = 1'b1;
      done_n     = 1'b0;
    end else begin
      case (state)
        SHOW: begin
          if (step) begin
            if (idx < LAST) begin
              idx_n   = idx + 4'd1;
              chunk_n = chunk_of(captured, idx + 4'd1);
            end else begin
              state_n = DONE;
              valid_n = 1'b0;
              done_n  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    // Decode from the next index so the digit changes on the same edge.
    seven_n = valid_n ? seg(idx_n) : BLANK;
  end

endmodule

// File: tb/tb_fsm_output.sv
// Randomized and directed bench for fsm_output, checked every cycle against a
// behavioural model of the chunk presenter.
module tb_fsm_output;

  localparam int DEB_LEN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [63:0] block = '0;
  logic        btn = 1'b0;
  logic [5:0]  chunk;
  logic [3:0]  idx;
  logic        valid, done;
  logic [6:0]  seven;

  int nvec = 0;
  int nerr = 0;

  fsm_output #(.BLOCK_W(64), .CHUNK_W(6), .NCHUNK(11), .DEB_LEN(DEB_LEN)) dut (
    .clk(clk), .rst(rst), .load(load), .block(block), .btn(btn),
    .chunk(chunk), .idx(idx), .valid(valid), .done(done), .seven(seven)
  );

  always #5 clk = ~clk;

  // Model: presented block, index, flags, and the length of the current run
  // of high button samples; a step is due the edge after the run hits DEB_LEN.
  logic [63:0] m_block;
  int          m_idx, run;
  bit          m_valid, m_done, pending;
  logic [6:0]  segtab [0:10];

  initial begin
    segtab[0] = 7'b0000001; segtab[1] = 7'b1001111; segtab[2] = 7'b0010010;
    segtab[3] = 7'b0000110; segtab[4] = 7'b1001100; segtab[5] = 7'b0100100;
    segtab[6] = 7'b0100000; segtab[7] = 7'b0001111; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0000100; segtab[10] = 7'b0001000;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_block = '0; m_idx = 0; m_valid = 0; m_done = 0; run = 0; pending = 0;
    end else begin
      if (load) begin
        m_block = block; m_idx = 0; m_valid = 1; m_done = 0;
      end else if (pending && m_valid) begin
        if (m_idx < 10) m_idx = m_idx + 1;
        else begin m_valid = 0; m_done = 1; end
      end
      run = btn ? ((run < 100) ? run + 1 : run) : 0;
      pending = (run == DEB_LEN);
    end
  end

  function automatic logic [5:0] exp_chunk();
    logic [63:0] sh;
    sh = m_block >> (6 * m_idx);
    return sh[5:0];
  endfunction

  function automatic logic [6:0] exp_seven();
    return m_valid ? segtab[m_idx] : 7'b1111111;
  endfunction

  always @(negedge clk) begin
    nvec++;
    if (chunk !== exp_chunk() || idx !== 4'(m_idx) || valid !== m_valid ||
        done !== m_done || seven !== exp_seven()) begin
      nerr++;
      $display("FAIL model t=%0t got chunk=%h idx=%0d valid=%b done=%b seven=%b exp chunk=%h idx=%0d valid=%b done=%b seven=%b",
               $time, chunk, idx, valid, done, seven,
               exp_chunk(), m_idx, m_valid, m_done, exp_seven());
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [63:0] b);
    load = 1'b1; block = b;
    tick(1);
    load = 1'b0; block = $urandom;
  endtask

  task automatic press();
    btn = 1'b1; tick(DEB_LEN + 2);
    btn = 1'b0; tick(3);
  endtask

  task automatic async_reset_check(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, "_chunk"}, 64'(chunk), 64'h0);
    check({name, "_idx"},   64'(idx),   64'h0);
    check({name, "_vd"},    64'({valid, done}), 64'h0);
    check({name, "_seven"}, 64'(seven), 64'h7F);
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    check("idle_seven", 64'(seven), 64'h7F);

    // Load and a single clean press with exact latency.
    do_load(64'h0123456789ABCDEF);
    check("load_chunk", 64'(chunk), 64'h2F);
    check("load_seven", 64'(seven), 64'b0000001);
    check("load_valid", 64'(valid), 64'h1);
    btn = 1'b1;
    tick(DEB_LEN);
    check("press_early_idx", 64'(idx), 64'h0);
    tick(1);
    check("press_idx", 64'(idx), 64'h1);
    check("press_chunk", 64'(chunk), 64'h37);
    check("press_seven", 64'(seven), 64'b1001111);
    btn = 1'b0; tick(3);

    // Short glitch is filtered; a long hold is one step.
    btn = 1'b1; tick(2); btn = 1'b0; tick(5);
    check("glitch_idx", 64'(idx), 64'h1);
    btn = 1'b1; tick(50); btn = 1'b0; tick(3);
    check("hold_idx", 64'(idx), 64'h2);

    // Walk to the last chunk, then past it.
    do_load(64'hF000000000000000);
    repeat (10) press();
    check("last_idx", 64'(idx), 64'd10);
    check("last_chunk", 64'(chunk), 64'h0F);
    check("last_seven", 64'(seven), 64'b0001000);
    press();
    check("done_flags", 64'({valid, done}), 64'b01);
    check("done_seven", 64'(seven), 64'h7F);
    press();
    check("done_hold", 64'({idx, chunk, done}), {53'd0, 4'd10, 6'h0F, 1'b1});

    // Load and step on the same edge: load wins.
    do_load(64'h0123456789ABCDEF);
    repeat (4) press();
    check("pre_idx4", 64'(idx), 64'd4);
    btn = 1'b1;
    tick(DEB_LEN);
    load = 1'b1; block = 64'h3F;
    tick(1);
    load = 1'b0;
    check("race_idx", 64'(idx), 64'h0);
    check("race_chunk", 64'(chunk), 64'h3F);
    check("race_done", 64'(done), 64'h0);
    btn = 1'b0; tick(3);

    // From DONE, reload with zero.
    repeat (11) press();
    check("done2", 64'(done), 64'h1);
    do_load(64'h0);
    check("reload", 64'({valid, done, idx, chunk}), {52'd0, 1'b1, 1'b0, 4'd0, 6'd0});

    // Reset mid-cycle and mid-press.
    do_load(64'hFEDCBA9876543210);
    press();
    btn = 1'b1; tick(1);
    async_reset_check("rst_mid");
    do_load(64'hFEDCBA9876543210);
    tick(DEB_LEN + 1);
    btn = 1'b0; tick(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        load = 1'b1; block = {$urandom, $urandom};
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      if ($urandom_range(0, 999) == 0) begin
        load = 1'b0;
        async_reset_check("rst_rand");
      end else begin
        tick(1);
      end
    end
    load = 1'b0; btn = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fsm_output.md
Name: fsm_output

Overview:
- Output-side counterpart to the 6-bit-chunk input collector.
- Accepts a 64-bit result block from the DES core with a one-cycle load strobe.
- Lets the user step through the block as 11 six-bit chunks using a raw push-button, in the same order the input collector assembles them.
- Drives the current chunk value, the chunk index, and an active-low seven-segment code of the index for the board display.

Parameters:
BLOCK_W, 64, width of the result block
CHUNK_W, 6, chunk width presented per step
NCHUNK, 11, chunks per block; the last chunk holds the residual BLOCK_W-(NCHUNK-1)*CHUNK_W bits
DEB_LEN, 3, button filter length in clk cycles

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
load  input  1  one-cycle strobe; captures block
block  input  64  result block, bits [64:1]
btn  input  1  raw step push-button, asynchronous to clk
chunk  output  6  current chunk, bits [6:1]
idx  output  4  current chunk index 0..10
valid  output  1  high while a captured block is being presented
done  output  1  high once the last chunk has been presented and stepped past
seven  output  7  active-low segment code {a,b,c,d,e,f,g} of idx; blank when not valid

Behaviour:
- Reset (async, rst=1) sets all of the following immediately, regardless of clk:
  - chunk=0, idx=0, valid=0, done=0, seven=7'b1111111
  - filter shift register=0, filtered level and its delayed copy=0
  - state=IDLE
- Button filter:
  - sr <= {sr[DEB_LEN-2:0], btn} every clk.
  - lvl = &sr; lvl_d <= lvl.
  - step = lvl & ~lvl_d, one cycle per press.
  - btn rising before edge 1 and held: step high in the cycle after edge DEB_LEN; effect registered at edge DEB_LEN+1.
  - Glitches shorter than DEB_LEN cycles produce no step.
  - Holding btn produces exactly one step.
- Chunk mapping: chunk k = captured[6k+6 : 6k+1] for k=0..9; chunk 10 = {2'b00, captured[64:61]}.
- States:
  - IDLE: valid=0, done=0, seven blank. load -> SHOW, capture block, idx=0, chunk=chunk 0, valid=1.
  - SHOW: step with idx<10 -> idx+1, chunk updated the same edge. step with idx==10 -> DONE, done=1, valid=0, chunk holds last value, idx holds 10.
  - DONE: step is ignored. load -> SHOW with the new block, idx=0, done=0.
- load has priority over step in every state; load in SHOW restarts at idx 0 with the new block.
- Outputs are registered; chunk, idx and seven change on the same edge. seven is decoded from the next idx value (no extra cycle).
- Seven-seg codes, index value -> code:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, 10=0001000 ("A")
  - Any other value = 1111111.
- idx never exceeds 10; no wrap-around, and a new load is required to restart.
- The block register holds its contents until the next load. block is sampled only on load.
- Reset mid-press: the filter clears, so a still-held btn after reset release yields one step after DEB_LEN+1 edges.

Test Plan:
1. Reset asserted asynchronously mid-cycle -> all outputs at reset values before the next clk edge; seven=1111111.
2. load with block=64'h0123456789ABCDEF -> next edge: valid=1, idx=0, chunk=6'h2F, seven=0000001. One clean press -> idx=1, chunk=6'h37, seven=1001111, exactly DEB_LEN+1 edges after btn rises.
3. btn glitch high for 2 cycles (DEB_LEN=3) -> no change. btn held 50 cycles -> single advance.
4. load 64'hF000000000000000, 10 presses -> idx=10, chunk=6'h0F, seven=0001000. 11th press -> done=1, valid=0. 12th press -> no change.
5. In SHOW at idx=4, load and step in the same cycle with block=64'h3F -> idx=0, chunk=6'h3F, done=0.
6. From DONE, load 64'h0 -> valid=1, done=0, idx=0, chunk=0.
